// File: rtl/ram_scan_reader.sv
// Scans a synchronous-read RAM address by address, dwelling between reads,
// and holds the last captured address/word pair for display.
module ram_scan_reader #(
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 4,
    parameter int TICKS_PER_STEP = 50_000_000
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              hold,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              sample,
    output logic              wrap
);

    localparam int CNT_W = $clog2(TICKS_PER_STEP + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICKS_PER_STEP - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DATA  = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] disp_addr_q;
    logic [DATA_W-1:0] disp_data_q;
    logic              disp_valid_q;
    logic              sample_q;
    logic              wrap_q;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rd_addr_q    <= '0;
            disp_addr_q  <= '0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            sample_q     <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            sample_q <= 1'b0;
            wrap_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable) state_q <= ST_ISSUE;
                end
                // enable is deliberately ignored here so a started read always completes
                ST_ISSUE: begin
                    state_q <= ST_DATA;
                end
                ST_DATA: begin
                    disp_data_q  <= rd_data;
                    disp_addr_q  <= rd_addr_q;
                    disp_valid_q <= 1'b1;
                    sample_q     <= 1'b1;
                    wrap_q       <= (rd_addr_q == '1);
                    rd_addr_q    <= rd_addr_q + ADDR_ONE;
                    cnt_q        <= '0;
                    state_q      <= enable ? ST_WAIT : ST_IDLE;
                end
                ST_WAIT: begin
                    if (!enable) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (!hold) begin
                        if (cnt_q == CNT_LAST) begin
                            state_q <= ST_ISSUE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rd_en      = (state_q == ST_ISSUE);
    assign rd_addr    = rd_addr_q;
    assign disp_addr  = disp_addr_q;
    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;
    assign sample     = sample_q;
    assign wrap       = wrap_q;

endmodule
